banked_bram: RTL and testbench
==============================

BANKED_BRAM -- requirements
Module: banked_bram

Interface
REQ-001 The block SHALL have these parameters:
  RAM_WIDTH, 128, data word width in bits.
  RAM_DEPTH, 256, number of words.
  LANE_W, 8, write-mask lane width; RAM_WIDTH SHALL be a multiple of LANE_W.
  READ_LATENCY, 1, cycles from accepted read to data; legal values 1 or 2.
REQ-002 The block SHALL define these derived widths: ADDR_W = clog2(RAM_DEPTH); NL = RAM_WIDTH/LANE_W.
REQ-003 The block SHALL have these ports, clock and reset first:
  clk          in   1          single clock, all logic on rising edge.
  rst_n        in   1          reset, asynchronous, active-low.
  wea          in   1          write enable.
  wmask        in   NL         per-lane write enable; bit i covers dina[i*LANE_W +: LANE_W].
  addra        in   ADDR_W     write address.
  dina         in   RAM_WIDTH  write data.
  enb          in   1          read enable.
  addrb        in   ADDR_W     read address.
  doutb        out  RAM_WIDTH  read data, registered.
  doutb_valid  out  1          one-cycle pulse marking new doutb.
  clr_start    in   1          request zero-fill of the whole array.
  clr_busy     out  1          zero-fill in progress.
  clr_done     out  1          one-cycle pulse on zero-fill completion.

Function
REQ-004 The block SHALL write a word when wea=1, clr_busy=0 and addra<RAM_DEPTH, and SHALL update only lanes whose wmask bit is 1.
REQ-005 The block SHALL accept a read when enb=1 and clr_busy=0, and SHALL drive doutb and doutb_valid=1 exactly READ_LATENCY cycles later.
REQ-006 Back-to-back reads SHALL be accepted every cycle with no bubbles.
REQ-007 A read of the address written in the same cycle SHALL return write-first data: masked lanes from dina, other lanes from the stored word.
REQ-008 A read with addrb>=RAM_DEPTH SHALL return all zeros with doutb_valid=1.
REQ-009 doutb SHALL hold its last value whenever doutb_valid=0.
REQ-010 With READ_LATENCY=2, the second stage SHALL be a plain output register, and write-first SHALL apply only to the cycle the read is accepted.
REQ-011 The clear engine SHALL be an FSM with states IDLE, CLEAR and DONE.
REQ-012 In IDLE, clr_start=1 SHALL move the FSM to CLEAR on the next edge and reset the clear counter to 0.
REQ-013 In CLEAR, the block SHALL write zero to the address given by the counter each cycle and increment the counter. At counter=RAM_DEPTH-1 it SHALL write that word, then move to DONE.
REQ-014 DONE SHALL last one cycle with clr_done=1, then return to IDLE. A full clear SHALL take RAM_DEPTH+1 cycles from the start edge to clr_done.
REQ-015 clr_busy SHALL be 1 in CLEAR and DONE, and 0 otherwise.
REQ-016 clr_start SHALL be ignored while clr_busy=1.
REQ-017 External writes and reads SHALL be ignored while clr_busy=1, with no doutb_valid generated.
REQ-018 If clr_start and wea/enb are asserted in the same cycle in IDLE, the write/read SHALL complete and the clear SHALL begin on the next edge.
REQ-019 Reads already in the READ_LATENCY pipeline when a clear starts SHALL still complete with their pre-clear data.

Reset
REQ-020 While rst_n=0, the block SHALL hold doutb=0, doutb_valid=0, clr_busy=0 and clr_done=0, with the FSM in IDLE, the counter at 0 and the read pipeline flushed.
REQ-021 Reset SHALL NOT alter array contents.
REQ-022 Reset asserted during CLEAR SHALL abort the clear, leaving addresses at or above the counter unmodified.
REQ-023 Deassertion of rst_n SHALL be taken synchronously to clk by the instantiating level. The first legal operation SHALL be on the first rising edge after deassertion.

Verification
REQ-024 Bench scenario 1: write A5..A5 to addr 3 with full mask, read addr 3 -> doutb=A5..A5 and doutb_valid=1 exactly READ_LATENCY cycles later.
REQ-025 Bench scenario 2: word 0x00..00 at addr 7; write 0xFF..FF with wmask=0x0001 -> readback low byte FF, all other bytes 00.
REQ-026 Bench scenario 3: same-cycle write 0x1234 to addr 9 and read of addr 9 -> doutb=0x1234, not the old data.
REQ-027 Bench scenario 4: fill all words nonzero, pulse clr_start -> clr_busy for 257 cycles (DEPTH 256), clr_done pulses once, and every address reads 0; a write and clr_start issued during busy have no effect.
REQ-028 Bench scenario 5: rst_n low at counter=100 during a clear -> outputs zero, FSM IDLE; addr 99 reads 0 and addr 100 reads its old value.
REQ-029 Bench scenario 6: repeat with READ_LATENCY=2 -> data arrives two cycles after the read is accepted, and continuous reads of 8 consecutive addresses produce 8 consecutive doutb_valid pulses.

Source files
------------

// File: rtl/banked_bram.sv
// banked_bram: lane-masked simple dual-port RAM with write-first reads, 1/2-cycle read latency and a zero-fill engine
module banked_bram #(
    parameter int RAM_WIDTH    = 128,
    parameter int RAM_DEPTH    = 256,
    parameter int LANE_W       = 8,
    parameter int READ_LATENCY = 1,
    localparam int ADDR_W      = $clog2(RAM_DEPTH),
    localparam int NL          = RAM_WIDTH / LANE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wea,
    input  logic [NL-1:0]        wmask,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic                 enb,
    input  logic [ADDR_W-1:0]    addrb,
    output logic [RAM_WIDTH-1:0] doutb,
    output logic                 doutb_valid,
    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic                 clr_done
);
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(RAM_DEPTH - 1);
    state_t state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] bmask, rd_word;
    logic wr_en, rd_en, rd_ok;
    genvar l;
    for (l = 0; l < NL; l++) begin : g_mask
        assign bmask[l*LANE_W +: LANE_W] = {LANE_W{wmask[l]}};
    end
    assign clr_busy = state != IDLE;
    assign clr_done = state == DONE;
    assign wr_en    = wea && !clr_busy && int'(addra) < RAM_DEPTH;
    assign rd_en    = enb && !clr_busy;
    assign rd_ok    = int'(addrb) < RAM_DEPTH;
    // write-first: a same-address write overrides only its enabled lanes
    assign rd_word  = !rd_ok ? '0 :
                      (wr_en && addra == addrb) ? (mem[addrb] & ~bmask) | (dina & bmask) : mem[addrb];
    // array has no reset; writes are held off while reset is asserted
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR)
                mem[cnt] <= '0;
            else if (wr_en)
                for (int i = 0; i < NL; i++)
                    if (wmask[i]) mem[addra][i*LANE_W +: LANE_W] <= dina[i*LANE_W +: LANE_W];
        end
    end
    always_comb begin
        state_nx = state == IDLE  ? (clr_start ? CLEAR : IDLE) :
                   state == CLEAR ? (cnt == LAST ? DONE : CLEAR) : IDLE;
        cnt_nx   = (state == CLEAR && cnt != LAST) ? cnt + 1'b1 : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    if (READ_LATENCY == 2) begin : g_l2
        logic [RAM_WIDTH-1:0] p_d;
        logic p_v;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p_d         <= '0;
                p_v         <= 1'b0;
                doutb       <= '0;
                doutb_valid <= 1'b0;
            end else begin
                p_v         <= rd_en;
                doutb_valid <= p_v;
                if (rd_en) p_d <= rd_word;
                if (p_v) doutb <= p_d;
            end
        end
    end else begin : g_l1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                doutb       <= '0;
                doutb_valid <= 1'b0;
            end else begin
                doutb_valid <= rd_en;
                if (rd_en) doutb <= rd_word;
            end
        end
    end
endmodule

// File: tb/tb_banked_bram.sv
// tb_banked_bram: table vectors plus clear/reset sequences, scoreboarded against latency-1 and latency-2 instances
module tb_banked_bram;
    typedef struct {
        logic         we;
        logic [15:0]  wm;
        logic [7:0]   wa;
        logic [127:0] wd;
        logic         en;
        logic [7:0]   ra;
        logic [127:0] exp;
    } vec_t;
    typedef struct {
        int           due;
        logic [127:0] d;
    } exp_t;
    logic clk = 0;
    logic rst_n = 0;
    logic wea = 0, enb = 0, clr_start = 0;
    logic [15:0] wmask = 0;
    logic [7:0] addra = 0, addrb = 0;
    logic [127:0] dina = 0;
    logic [127:0] dout [2];
    logic vld [2], busy [2], done [2];
    logic [127:0] last [2];
    logic [127:0] ref_mem [256];
    exp_t sbq [2][$];
    vec_t tbl [12];
    int cyc = 0, n_chk = 0, n_fail = 0;
    int bc, dc, b1c, d1c, vc, run, mrun;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    banked_bram #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wea(wea), .wmask(wmask), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(dout[0]), .doutb_valid(vld[0]),
        .clr_start(clr_start), .clr_busy(busy[0]), .clr_done(done[0]));
    banked_bram #(.READ_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .wea(wea), .wmask(wmask), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(dout[1]), .doutb_valid(vld[1]),
        .clr_start(clr_start), .clr_busy(busy[1]), .clr_done(done[1]));
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        wea = 0; enb = 0; clr_start = 0; wmask = 0;
    endtask
    task automatic push_rd(input logic [127:0] d);
        sbq[0].push_back('{cyc + 1, d});
        sbq[1].push_back('{cyc + 2, d});
    endtask
    task automatic wr(input int a, input logic [127:0] d);
        wea = 1; wmask = 16'hFFFF; addra = 8'(a); dina = d; ref_mem[a] = d;
    endtask
    initial forever begin
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                last[i] = dout[i];
            end else if (vld[i]) begin
                if (sbq[i].size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_valid inst%0d: got valid with %h, want no output", i, dout[i]);
                end else begin
                    e = sbq[i].pop_front();
                    chk($sformatf("rd_cycle_l%0d", i + 1), 128'(cyc), 128'(e.due));
                    chk($sformatf("rd_data_l%0d", i + 1), dout[i], e.d);
                end
                last[i] = dout[i];
            end else begin
                chk($sformatf("hold_l%0d", i + 1), dout[i], last[i]);
                if (sbq[i].size() > 0 && sbq[i][0].due <= cyc) begin
                    e = sbq[i].pop_front();
                    n_chk++; n_fail++;
                    $display("FAIL missed_valid inst%0d: got no valid at cycle %0d, want data %h", i, cyc, e.d);
                end
            end
        end
    end
    initial begin
        tbl[0]  = '{1'b1, 16'hFFFF, 8'd3,  {16{8'hA5}}, 1'b0, 8'd0,  128'h0};
        tbl[1]  = '{1'b0, 16'h0000, 8'd0,  128'h0,      1'b1, 8'd3,  {16{8'hA5}}};
        tbl[2]  = '{1'b1, 16'hFFFF, 8'd7,  128'h0,      1'b0, 8'd0,  128'h0};
        tbl[3]  = '{1'b1, 16'h0001, 8'd7,  {16{8'hFF}}, 1'b0, 8'd0,  128'h0};
        tbl[4]  = '{1'b0, 16'h0000, 8'd0,  128'h0,      1'b1, 8'd7,  128'hFF};
        tbl[5]  = '{1'b1, 16'hFFFF, 8'd9,  128'hDEAD,   1'b0, 8'd0,  128'h0};
        tbl[6]  = '{1'b1, 16'hFFFF, 8'd9,  128'h1234,   1'b1, 8'd9,  128'h1234};
        tbl[7]  = '{1'b1, 16'h0002, 8'd9,  {16{8'hAB}}, 1'b1, 8'd9,  128'hAB34};
        tbl[8]  = '{1'b0, 16'h0000, 8'd0,  128'h0,      1'b1, 8'd3,  {16{8'hA5}}};
        tbl[9]  = '{1'b0, 16'h0000, 8'd0,  128'h0,      1'b1, 8'd7,  128'hFF};
        tbl[10] = '{1'b1, 16'hFFFF, 8'd12, 128'h55,     1'b1, 8'd9,  128'hAB34};
        tbl[11] = '{1'b0, 16'h0000, 8'd0,  128'h0,      1'b1, 8'd12, 128'h55};
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_doutb", dout[i], 128'h0);
            chk("rst_valid", 128'(vld[i]), 128'h0);
            chk("rst_busy", 128'(busy[i]), 128'h0);
            chk("rst_done", 128'(done[i]), 128'h0);
        end
        rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            wea = tbl[i].we; wmask = tbl[i].wm; addra = tbl[i].wa; dina = tbl[i].wd;
            enb = tbl[i].en; addrb = tbl[i].ra;
            if (tbl[i].en) push_rd(tbl[i].exp);
            step();
        end
        idle();
        repeat (4) step();
        // full clear of a nonzero array, with a read and write in the start cycle
        for (int i = 0; i < 256; i++) begin
            wr(i, {{15{8'h3C}}, 8'(i)});
            step();
        end
        idle();
        clr_start = 1; enb = 1; addrb = 8'd5; push_rd(ref_mem[5]);
        wea = 1; wmask = 16'hFFFF; addra = 8'd6; dina = {16{8'hFF}};
        step();
        idle();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        bc = 0; dc = 0; b1c = 0; d1c = 0;
        while (busy[0] && bc < 400) begin
            bc++;
            dc += int'(done[0]);
            b1c += int'(busy[1]);
            d1c += int'(done[1]);
            if (bc == 50) begin
                wea = 1; wmask = 16'hFFFF; addra = 8'd0; dina = {16{8'h77}};
                clr_start = 1; enb = 1; addrb = 8'd0;
            end else idle();
            step();
        end
        idle();
        chk("clr_busy_cycles_l1", 128'(bc), 128'd257);
        chk("clr_done_pulses_l1", 128'(dc), 128'd1);
        chk("clr_busy_cycles_l2", 128'(b1c), 128'd257);
        chk("clr_done_pulses_l2", 128'(d1c), 128'd1);
        for (int i = 0; i < 256; i++) begin
            enb = 1; addrb = 8'(i); push_rd(ref_mem[i]);
            step();
        end
        idle();
        repeat (4) step();
        // reset in the middle of a clear, counter at 100
        for (int i = 98; i < 102; i++) begin
            wr(i, {8{16'(i + 16'hC000)}});
            step();
        end
        idle();
        clr_start = 1;
        step();
        idle();
        repeat (100) step();
        rst_n = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("abort_doutb", dout[i], 128'h0);
            chk("abort_valid", 128'(vld[i]), 128'h0);
            chk("abort_busy", 128'(busy[i]), 128'h0);
            chk("abort_done", 128'(done[i]), 128'h0);
        end
        for (int i = 0; i < 100; i++) ref_mem[i] = '0;
        step();
        step();
        rst_n = 1;
        for (int i = 98; i < 102; i++) begin
            enb = 1; addrb = 8'(i); push_rd(ref_mem[i]);
            step();
        end
        idle();
        repeat (4) step();
        // eight back-to-back reads
        for (int i = 20; i < 28; i++) begin
            wr(i, {4{32'(i * 32'h01010101)}});
            step();
        end
        idle();
        vc = 0; run = 0; mrun = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                enb = 1; addrb = 8'(20 + i); push_rd(ref_mem[20 + i]);
            end else idle();
            step();
            vc += int'(vld[1]);
            run = vld[1] ? run + 1 : 0;
            if (run > mrun) mrun = run;
        end
        idle();
        chk("l2_burst_pulses", 128'(vc), 128'd8);
        chk("l2_burst_run", 128'(mrun), 128'd8);
        repeat (4) step();
        chk("sb_empty_l1", 128'(sbq[0].size()), 128'd0);
        chk("sb_empty_l2", 128'(sbq[1].size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
